// File: rtl/dbg_req_sequencer.sv
// Debug-request sequencer: delayed, masked request pulse per core,
// then sticky halt-ack collection with an optional timeout.
module dbg_req_sequencer #(
  parameter int NUM_CORES = 2,
  parameter int CNT_W     = 16,
  parameter int LEN_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_CORES-1:0] core_mask_i,
  input  logic [CNT_W-1:0]     delay_i,
  input  logic [LEN_W-1:0]     pulse_len_i,
  input  logic [CNT_W-1:0]     timeout_i,
  input  logic [NUM_CORES-1:0] halted_i,
  output logic [NUM_CORES-1:0] debug_req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [NUM_CORES-1:0] halted_mask_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_ACK,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [NUM_CORES-1:0] r_mask;
  logic [NUM_CORES-1:0] r_req;
  logic [NUM_CORES-1:0] r_hmask;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_tmo;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_len_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_to;

  logic [LEN_W-1:0]     w_len_in;
  logic [NUM_CORES-1:0] w_hnext;
  logic                 w_all;

  // A zero pulse length still produces one request cycle.
  assign w_len_in = (pulse_len_i == '0) ? LEN_W'(1) : pulse_len_i;
  assign w_hnext  = r_hmask | (halted_i & r_mask);
  assign w_all    = (w_hnext == r_mask);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_req     <= '0;
      r_hmask   <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_len     <= '0;
      r_len_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
    end else if (r_state != S_IDLE && abort_i) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i && !abort_i) begin
            r_mask  <= core_mask_i;
            r_len   <= w_len_in;
            r_tmo   <= timeout_i;
            r_hmask <= '0;
            r_to    <= 1'b0;
            r_busy  <= 1'b1;
            if (core_mask_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (delay_i == '0) begin
              r_state   <= S_REQ;
              r_req     <= core_mask_i;
              r_len_cnt <= w_len_in;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= delay_i;
            end
          end
        end
        S_WAIT: begin
          r_hmask <= w_hnext;
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= S_REQ;
            r_req     <= r_mask;
            r_len_cnt <= r_len;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_REQ: begin
          r_hmask <= w_hnext;
          if (r_len_cnt == LEN_W'(1)) begin
            r_state <= S_ACK;
            r_req   <= '0;
            r_cnt   <= r_tmo;
          end else begin
            r_len_cnt <= r_len_cnt - LEN_W'(1);
          end
        end
        S_ACK: begin
          r_hmask <= w_hnext;
          // Completion takes priority over a timeout in the same cycle.
          if (w_all) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_to    <= 1'b0;
          end else if (r_tmo != '0 && r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_to    <= 1'b1;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign debug_req_o   = r_req;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign timeout_o     = r_to;
  assign halted_mask_o = r_hmask;

endmodule

// File: tb/tb_dbg_req_sequencer.sv
// Bench for dbg_req_sequencer: vector table, corner sequences and a
// randomized run against a phase-arithmetic reference model.
module tb_dbg_req_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  core_mask;
  logic [15:0] delay;
  logic [3:0]  plen;
  logic [15:0] tmo;
  logic [1:0]  halted;
  logic [1:0]  dreq;
  logic        busy;
  logic        done;
  logic        to;
  logic [1:0]  hmask;

  int checks = 0;
  int failures = 0;

  dbg_req_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .abort_i       (abort),
    .core_mask_i   (core_mask),
    .delay_i       (delay),
    .pulse_len_i   (plen),
    .timeout_i     (tmo),
    .halted_i      (halted),
    .debug_req_o   (dreq),
    .busy_o        (busy),
    .done_o        (done),
    .timeout_o     (to),
    .halted_mask_o (hmask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mask;
    int         dly;
    int         len;
    int         tmo;
    int         ack_at;
    logic [1:0] ack_val;
    int         e_first;
    int         e_last;
    int         e_done;
    logic       e_to;
    logic [1:0] e_hm;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick;
      n++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   first, last, dcyc;
    logic bad_req, bad_busy, to_s;
    logic [1:0] hm_s;
    string s;
    first = -1; last = -1; dcyc = -1;
    bad_req = 0; bad_busy = 0; to_s = 0; hm_s = 0;
    core_mask = v.mask;
    delay     = 16'(v.dly);
    plen      = 4'(v.len);
    tmo       = 16'(v.tmo);
    start     = 1'b1;
    halted    = (v.ack_at <= 0) ? v.ack_val : 2'b00;
    for (int n = 1; n <= 1500; n++) begin
      tick;
      start = 1'b0;
      if (dreq != 2'b00) begin
        if (first < 0) first = n;
        last = n;
        if (dreq != v.mask) bad_req = 1'b1;
      end
      if (dcyc < 0) begin
        if (!busy) bad_busy = 1'b1;
      end else if (busy) begin
        bad_busy = 1'b1;
      end
      if (done && dcyc < 0) begin
        dcyc = n;
        to_s = to;
        hm_s = hmask;
      end
      halted = (n >= v.ack_at) ? v.ack_val : 2'b00;
      if (dcyc >= 0 && n > dcyc) break;
    end
    halted = 2'b00;
    s = $sformatf("vec%0d", idx);
    chk({s, "_req_first"}, first, v.e_first);
    chk({s, "_req_last"}, last, v.e_last);
    chk({s, "_req_val"}, {31'd0, bad_req}, 32'd0);
    chk({s, "_busy"}, {31'd0, bad_busy}, 32'd0);
    chk({s, "_done_cyc"}, dcyc, v.e_done);
    chk({s, "_timeout"}, {31'd0, to_s}, {31'd0, v.e_to});
    chk({s, "_hmask"}, {30'd0, hm_s}, {30'd0, v.e_hm});
  endtask

  // Fresh minimal sequence: request cycle 1, done cycle 3.
  task automatic quick_start(input string nm);
    core_mask = 2'b01; delay = 16'd0; plen = 4'd1; tmo = 16'd0;
    halted = 2'b01; start = 1'b1;
    tick;
    start = 1'b0;
    chk({nm, "_req1"}, {30'd0, dreq}, 32'd1);
    tick;
    tick;
    chk({nm, "_done3"}, {31'd0, done}, 32'd1);
    chk({nm, "_hm"}, {30'd0, hmask}, 32'd1);
    halted = 2'b00;
    tick;
  endtask

  // Reference model: sequence phase derived from cycle offset n.
  logic       m_act;
  int         m_n, m_d, m_p, m_t, m_done_at;
  logic [1:0] m_mask, m_hm;
  logic       m_to;

  task automatic model_step;
    if (rst) begin
      m_act = 0; m_to = 0; m_hm = 0;
    end else if (m_act && abort) begin
      m_act = 0;
    end else if (!m_act) begin
      if (start && !abort) begin
        m_act = 1; m_n = 1; m_mask = core_mask;
        m_d = int'(delay);
        m_p = (plen == 0) ? 1 : int'(plen);
        m_t = int'(tmo);
        m_hm = 0; m_to = 0;
        m_done_at = (core_mask == 0) ? 1 : -1;
      end
    end else if (m_n == m_done_at) begin
      m_act = 0;
    end else begin
      m_hm = m_hm | (halted & m_mask);
      if (m_n > m_d + m_p) begin
        if (m_hm == m_mask) begin
          m_done_at = m_n + 1;
        end else if (m_t != 0 && m_n - m_d - m_p == m_t) begin
          m_done_at = m_n + 1;
          m_to = 1;
        end
      end
      m_n++;
    end
  endtask

  initial begin
    logic       dseen;
    logic [6:0] exp_v, act_v;
    logic [1:0] e_req;

    vecs[0] = '{2'b01, 20, 1,  0, 25,   2'b01, 21, 21, 26,   1'b0, 2'b01};
    vecs[1] = '{2'b11, 0,  0,  3, 9999, 2'b00, 1,  1,  5,    1'b1, 2'b00};
    vecs[2] = '{2'b11, 2,  2,  5, 1,    2'b01, 3,  4,  10,   1'b1, 2'b01};
    vecs[3] = '{2'b01, 0,  1,  0, 0,    2'b01, 1,  1,  3,    1'b0, 2'b01};
    vecs[4] = '{2'b00, 5,  2,  0, 0,    2'b11, -1, -1, 1,    1'b0, 2'b00};
    vecs[5] = '{2'b11, 0,  1,  2, 3,    2'b11, 1,  1,  4,    1'b0, 2'b11};
    vecs[6] = '{2'b10, 3,  15, 0, 0,    2'b11, 4,  18, 20,   1'b0, 2'b10};
    vecs[7] = '{2'b11, 0,  1,  0, 1002, 2'b11, 1,  1,  1003, 1'b0, 2'b11};

    rst = 1'b1; start = 1'b0; abort = 1'b0; core_mask = 2'b00;
    delay = 16'd0; plen = 4'd0; tmo = 16'd0; halted = 2'b00;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("rst_req", {30'd0, dreq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_to", {31'd0, to}, 32'd0);
    chk("rst_hm", {30'd0, hmask}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      wait_idle;
      run_vec(vecs[i], i);
    end

    // Abort in the 2nd of 4 request cycles.
    wait_idle;
    core_mask = 2'b11; delay = 16'd2; plen = 4'd4; tmo = 16'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("abort_req_c3", {30'd0, dreq}, 32'd3);
    tick;
    chk("abort_req_c4", {30'd0, dreq}, 32'd3);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_req_c5", {30'd0, dreq}, 32'd0);
    chk("abort_busy_c5", {31'd0, busy}, 32'd0);
    dseen = done;
    repeat (6) begin
      tick;
      if (done) dseen = 1'b1;
    end
    chk("abort_no_done", {31'd0, dseen}, 32'd0);
    quick_start("abort_restart");

    // Reset during WAIT.
    core_mask = 2'b11; delay = 16'd10; plen = 4'd1; tmo = 16'd0;
    halted = 2'b10; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("rstw_busy", {31'd0, busy}, 32'd1);
    chk("rstw_hm_pre", {30'd0, hmask}, 32'd2);
    rst = 1'b1;
    halted = 2'b00;
    tick;
    rst = 1'b0;
    chk("rstw_busy0", {31'd0, busy}, 32'd0);
    chk("rstw_req0", {30'd0, dreq}, 32'd0);
    chk("rstw_hm0", {30'd0, hmask}, 32'd0);
    dseen = done;
    repeat (4) begin
      tick;
      if (done) dseen = 1'b1;
    end
    chk("rstw_no_done", {31'd0, dseen}, 32'd0);
    quick_start("rstw_restart");

    // Start pulsed during ACK is ignored.
    core_mask = 2'b11; delay = 16'd0; plen = 4'd1; tmo = 16'd4;
    halted = 2'b01; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    core_mask = 2'b01; tmo = 16'd0; plen = 4'd5; start = 1'b1;
    tick;
    start = 1'b0;
    chk("ackstart_req", {30'd0, dreq}, 32'd0);
    tick;
    tick;
    chk("ackstart_nodone5", {31'd0, done}, 32'd0);
    tick;
    chk("ackstart_done6", {31'd0, done}, 32'd1);
    chk("ackstart_to", {31'd0, to}, 32'd1);
    chk("ackstart_hm", {30'd0, hmask}, 32'd1);
    halted = 2'b00;
    tick;

    // Start together with abort in IDLE is ignored.
    core_mask = 2'b11; delay = 16'd0; plen = 4'd1; tmo = 16'd0;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", {31'd0, busy}, 32'd0);
    chk("sa_req", {30'd0, dreq}, 32'd0);
    tick;
    chk("sa_busy2", {31'd0, busy}, 32'd0);
    chk("sa_to_kept", {31'd0, to}, 32'd1);
    chk("sa_hm_kept", {30'd0, hmask}, 32'd1);

    // Randomized run against the reference model.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_act = 0; m_to = 0; m_hm = 0; m_n = 0; m_d = 0; m_p = 1;
    m_t = 0; m_done_at = -1; m_mask = 0;
    for (int i = 0; i < 4000; i++) begin
      tick;
      e_req = (m_act && m_n > m_d && m_n <= m_d + m_p) ? m_mask : 2'b00;
      exp_v = {e_req, m_act, (m_act && m_n == m_done_at), m_to, m_hm};
      act_v = {dreq, busy, done, to, hmask};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rand_cyc%0d: got %b expected %b", i, act_v, exp_v);
      end
      rst       = ($urandom_range(0, 199) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      start     = ($urandom_range(0, 3) == 0);
      core_mask = 2'($urandom_range(0, 3));
      delay     = 16'($urandom_range(0, 4));
      plen      = 4'($urandom_range(0, 3));
      tmo       = 16'($urandom_range(0, 5));
      halted    = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      model_step;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
